// File: rtl/key_pkg.sv
// Shared definitions for the PS/2 key event path.
//  - scan-code constants for the prefix bytes and the four arrow keys
//  - decoder state encoding
//  - bit positions of the arrow keys inside the held vector {up,left,down,right}
//  - arrow_mask(): one-hot held mask for an extended arrow code, 0 otherwise
package key_pkg;

    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_BRK   = 8'hF0;
    localparam logic [7:0] SC_PAUSE = 8'hE1;
    localparam logic [7:0] SC_UP    = 8'h75;
    localparam logic [7:0] SC_LEFT  = 8'h6B;
    localparam logic [7:0] SC_DOWN  = 8'h72;
    localparam logic [7:0] SC_RIGHT = 8'h74;

    // Bytes following E1 that belong to the Pause sequence.
    localparam logic [2:0] PAUSE_TAIL = 3'd7;

    localparam int unsigned HELD_UP    = 3;
    localparam int unsigned HELD_LEFT  = 2;
    localparam int unsigned HELD_DOWN  = 1;
    localparam int unsigned HELD_RIGHT = 0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_EXT,
        ST_BRK,
        ST_EXTBRK,
        ST_PAUSE
    } dec_state_t;

    function automatic logic [3:0] arrow_mask(input logic ext, input logic [7:0] code);
        logic [3:0] m;
        m = '0;
        if (ext) begin
            case (code)
                SC_UP:    m[HELD_UP]    = 1'b1;
                SC_LEFT:  m[HELD_LEFT]  = 1'b1;
                SC_DOWN:  m[HELD_DOWN]  = 1'b1;
                SC_RIGHT: m[HELD_RIGHT] = 1'b1;
                default:  m = '0;
            endcase
        end
        return m;
    endfunction

endpackage

// File: rtl/key_fifo.sv
// Synchronous first-word-fall-through FIFO.
// Ports:
//  clock, reset  : clock, synchronous active-high reset
//  push          : write push_data (accepted when not full, or when full and popping)
//  push_data     : entry to write
//  pop           : remove head entry (ignored when empty)
//  head          : current head entry (0 when empty)
//  empty, full   : occupancy flags
//  fill          : occupancy 0..DEPTH
module key_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned AW    = 3,
    parameter int unsigned WIDTH = 9
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             empty,
    output logic             full,
    output logic [AW:0]      fill
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic             do_pop;
    logic             do_push;

    assign empty   = (fill == '0);
    assign full    = (fill == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    // When full, a write is only possible if the head leaves in the same cycle;
    // the slot being written is then the one being vacated.
    assign do_push = push && (!full || do_pop);
    assign head    = empty ? '0 : mem[rptr];

    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wptr] <= push_data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wptr <= '0;
            rptr <= '0;
            fill <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   fill <= fill + 1'b1;
                2'b01:   fill <= fill - 1'b1;
                default: fill <= fill;
            endcase
        end
    end

endmodule

// File: rtl/key_event_ctrl.sv
// PS/2 scan-code decoder: turns raw byte strobes into make/break events,
// filters typematic repeats, queues make events in a FWFT FIFO and tracks
// the held state of the four extended arrow keys.
// Ports:
//  clock, reset     : clock, synchronous active-high reset
//  ps2_key_pressed  : one-cycle strobe, new byte on ps2_key_data
//  ps2_key_data     : received scan-code byte
//  key_ack          : pop head entry (honoured only while key_valid)
//  ovf_clr          : clear sticky overflow
//  key_valid        : FIFO non-empty, head presented on key_code/key_ext
//  key_code         : head make code (prefix stripped)
//  key_ext          : head entry was E0-extended
//  held             : {up,left,down,right} currently held
//  overflow         : sticky, a make event was dropped on a full FIFO
//  fill             : FIFO occupancy 0..DEPTH
module key_event_ctrl
    import key_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned AW    = 3
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          ps2_key_pressed,
    input  logic [7:0]    ps2_key_data,
    input  logic          key_ack,
    input  logic          ovf_clr,
    output logic          key_valid,
    output logic [7:0]    key_code,
    output logic          key_ext,
    output logic [3:0]    held,
    output logic          overflow,
    output logic [AW:0]   fill
);

    dec_state_t state, state_next;
    logic [2:0] pause_cnt, pause_cnt_next;

    logic       make_ev;
    logic       brk_ev;
    logic       ev_ext;
    logic [8:0] ev_key;

    logic [8:0] last_make;
    logic       last_valid;
    logic       is_repeat;
    logic       push;
    logic       pop;
    logic [8:0] head;
    logic       empty;
    logic       full;
    logic [3:0] ev_mask;

    // Decoder next-state and event generation.
    always_comb begin
        state_next     = state;
        pause_cnt_next = pause_cnt;
        make_ev        = 1'b0;
        brk_ev         = 1'b0;
        ev_ext         = 1'b0;
        if (ps2_key_pressed) begin
            case (state)
                ST_IDLE: begin
                    if (ps2_key_data == SC_EXT) begin
                        state_next = ST_EXT;
                    end else if (ps2_key_data == SC_BRK) begin
                        state_next = ST_BRK;
                    end else if (ps2_key_data == SC_PAUSE) begin
                        state_next     = ST_PAUSE;
                        pause_cnt_next = PAUSE_TAIL;
                    end else begin
                        make_ev = 1'b1;
                    end
                end
                ST_EXT: begin
                    if (ps2_key_data == SC_BRK) begin
                        state_next = ST_EXTBRK;
                    end else if (ps2_key_data == SC_EXT || ps2_key_data == SC_PAUSE) begin
                        state_next = ST_EXT;
                    end else begin
                        make_ev    = 1'b1;
                        ev_ext     = 1'b1;
                        state_next = ST_IDLE;
                    end
                end
                ST_BRK: begin
                    brk_ev     = 1'b1;
                    state_next = ST_IDLE;
                end
                ST_EXTBRK: begin
                    brk_ev     = 1'b1;
                    ev_ext     = 1'b1;
                    state_next = ST_IDLE;
                end
                ST_PAUSE: begin
                    pause_cnt_next = pause_cnt - 1'b1;
                    if (pause_cnt == 3'd1) state_next = ST_IDLE;
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= ST_IDLE;
            pause_cnt <= '0;
        end else begin
            state     <= state_next;
            pause_cnt <= pause_cnt_next;
        end
    end

    assign ev_key    = {ev_ext, ps2_key_data};
    assign ev_mask   = arrow_mask(ev_ext, ps2_key_data);
    assign is_repeat = last_valid && (last_make == ev_key);
    assign push      = make_ev && !is_repeat;
    assign pop       = key_ack && !empty;

    // Repeat filter, held flags and sticky overflow.
    always_ff @(posedge clock) begin
        if (reset) begin
            last_make  <= '0;
            last_valid <= 1'b0;
            held       <= '0;
            overflow   <= 1'b0;
        end else begin
            if (push) begin
                last_make  <= ev_key;
                last_valid <= 1'b1;
            end else if (brk_ev && is_repeat) begin
                last_valid <= 1'b0;
            end

            if (make_ev)     held <= held | ev_mask;
            else if (brk_ev) held <= held & ~ev_mask;

            if (push && full && !pop) overflow <= 1'b1;
            else if (ovf_clr)         overflow <= 1'b0;
        end
    end

    key_fifo #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .WIDTH (9)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (push),
        .push_data (ev_key),
        .pop       (key_ack),
        .head      (head),
        .empty     (empty),
        .full      (full),
        .fill      (fill)
    );

    assign key_valid = !empty;
    assign key_code  = head[7:0];
    assign key_ext   = head[8];

endmodule
